// File: rtl/eth_tx_framer_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the MII transmit framer.
package eth_tx_framer_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_PRE  = 4'd1,
        S_DA   = 4'd2,
        S_SA   = 4'd3,
        S_TYP  = 4'd4,
        S_FID  = 4'd5,
        S_DATA = 4'd6,
        S_CRC  = 4'd7,
        S_IFG  = 4'd8
    } state_t;

    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam int          PREAMBLE_NIB = 15;
    localparam logic [3:0]  PRE_NIB      = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam int          MAC_NIB      = 12;
    localparam int          TYP_NIB      = 4;
    localparam int          CRC_NIB      = 8;

    function automatic int data_nib(input int uframe_len, input int num_uframe);
        return (uframe_len * num_uframe) / 4;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eth_crc32_nibble.sv
// One nibble step of the reflected IEEE CRC-32; data bits are consumed LSB first.
module eth_crc32_nibble
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [3:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c_s;

    // Four serial LFSR steps, one per data bit.
    always_comb begin
        c_s = crc_i;
        for (int i = 0; i < 4; i++) begin
            if (c_s[0] ^ data_i[i]) begin
                c_s = (c_s >> 1) ^ CRC_POLY;
            end else begin
                c_s = c_s >> 1;
            end
        end
        crc_o = c_s;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// MII transmit framer: packs a serial bit stream into ping-pong nibble buffers and
// sends each full buffer as one Ethernet frame with FCS and inter-frame gap.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int          UFRAME_LEN  = 148,
    parameter int          NUM_UFRAME  = 8,
    parameter int          FRAMEID_LEN = 8,
    parameter logic [47:0] DA          = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SA          = 48'h0200_0000_0001,
    parameter logic [15:0] TYPELEN     = 16'h076C,
    parameter int          IFG_NIB     = 24
) (
    input  logic                   phy_txclk,
    input  logic                   rst_n,
    input  logic                   tx_go,
    input  logic                   ff_bit,
    input  logic                   ff_bit_valid,
    output logic [3:0]             phy_txd,
    output logic                   phy_txen,
    output logic                   phy_txer,
    output logic [FRAMEID_LEN-1:0] frameid,
    output logic                   overflow
);

    localparam int DATA_NIB = data_nib(UFRAME_LEN, NUM_UFRAME);
    localparam int FID_NIB  = FRAMEID_LEN / 4;
    localparam int NIB_W    = cnt_width(DATA_NIB);
    localparam int CNT_MAX  = (DATA_NIB > IFG_NIB) ? ((DATA_NIB > 16) ? DATA_NIB : 16)
                                                   : ((IFG_NIB > 16) ? IFG_NIB : 16);
    localparam int CNT_W    = cnt_width(CNT_MAX);

    logic [3:0]       wbuf_q [2][DATA_NIB];
    logic [3:0]       nib_q;
    logic [1:0]       bit_cnt_q;
    logic [NIB_W-1:0] nib_idx_q;
    logic             wptr_q;
    logic [1:0]       full_q, full_d;
    logic             overflow_q;
    logic [3:0]       nib_s;
    logic             accept_s, nib_done_s, buf_done_s, release_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rptr_q, rptr_d;
    logic [FRAMEID_LEN-1:0] frameid_q, frameid_d;
    logic [31:0]            crc_q, crc_d, crc_upd_s, crc_src_s, crc_sh_s;
    logic [3:0]             txd_q, txd_d;
    logic                   txen_q, txen_d;
    logic [47:0]            mac_sh_s;
    logic [FRAMEID_LEN-1:0] fid_sh_s;

    eth_crc32_nibble u_crc (
        .crc_i  (crc_q),
        .data_i (txd_q),
        .crc_o  (crc_upd_s)
    );

    // Write-side bit assembly and buffer occupancy.
    always_comb begin
        nib_s             = nib_q;
        nib_s[bit_cnt_q]  = ff_bit;
        accept_s          = ff_bit_valid && !full_q[wptr_q];
        nib_done_s        = accept_s && (bit_cnt_q == 2'd3);
        buf_done_s        = nib_done_s && (nib_idx_q == NIB_W'(DATA_NIB - 1));
        full_d            = full_q;
        if (release_s) begin
            full_d[rptr_q] = 1'b0;
        end else begin
            full_d[rptr_q] = full_q[rptr_q];
        end
        if (buf_done_s) begin
            full_d[wptr_q] = 1'b1;
        end else begin
            full_d[wptr_q] = full_d[wptr_q];
        end
    end

    // Write-side counters, pointer, occupancy flags and overflow pulse.
    always_ff @(posedge phy_txclk) begin
        if (!rst_n) begin
            nib_q      <= 4'h0;
            bit_cnt_q  <= 2'd0;
            nib_idx_q  <= '0;
            wptr_q     <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= ff_bit_valid && full_q[wptr_q];
            full_q     <= full_d;
            if (accept_s) begin
                nib_q     <= nib_s;
                bit_cnt_q <= bit_cnt_q + 2'd1;
            end
            if (nib_done_s) begin
                nib_idx_q <= buf_done_s ? '0 : nib_idx_q + NIB_W'(1'b1);
            end
            if (buf_done_s) begin
                wptr_q <= ~wptr_q;
            end
        end
    end

    // Payload storage; contents are only meaningful while the matching full flag is set.
    always_ff @(posedge phy_txclk) begin
        if (rst_n && nib_done_s) begin
            wbuf_q[wptr_q][nib_idx_q] <= nib_s;
        end
    end

    // Read-side sequencing: advance (state, nibble index) one nibble per clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1'b1);
        rptr_d    = rptr_q;
        frameid_d = frameid_q;
        crc_d     = crc_q;
        release_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_go && full_q[rptr_q]) begin
                    state_d = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                crc_d = CRC_INIT;
                if (cnt_q == CNT_W'(PREAMBLE_NIB)) begin
                    state_d = S_DA;
                    cnt_d   = '0;
                end else begin
                    state_d = S_PRE;
                end
            end
            S_DA, S_SA: begin
                crc_d = crc_upd_s;
                if (cnt_q == CNT_W'(MAC_NIB - 1)) begin
                    state_d = (state_q == S_DA) ? S_SA : S_TYP;
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_TYP: begin
                crc_d = crc_upd_s;
                if (cnt_q == CNT_W'(TYP_NIB - 1)) begin
                    state_d = S_FID;
                    cnt_d   = '0;
                end else begin
                    state_d = S_TYP;
                end
            end
            S_FID: begin
                crc_d = crc_upd_s;
                if (cnt_q == CNT_W'(FID_NIB - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    state_d = S_FID;
                end
            end
            S_DATA: begin
                crc_d = crc_upd_s;
                if (cnt_q == CNT_W'(DATA_NIB - 1)) begin
                    state_d   = S_CRC;
                    cnt_d     = '0;
                    release_s = 1'b1;
                    rptr_d    = ~rptr_q;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CRC: begin
                if (cnt_q == CNT_W'(CRC_NIB - 1)) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end else begin
                    state_d = S_CRC;
                end
            end
            S_IFG: begin
                if (cnt_q == CNT_W'(IFG_NIB - 1)) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    frameid_d = frameid_q + FRAMEID_LEN'(1'b1);
                end else begin
                    state_d = S_IFG;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Nibble to present for the next position; the FCS source includes the last data nibble on CRC entry.
    always_comb begin
        crc_src_s = (state_q == S_DATA) ? crc_upd_s : crc_q;
        crc_sh_s  = ~crc_src_s >> {cnt_d, 2'b00};
        mac_sh_s  = ((state_d == S_DA) ? DA : SA) >> {cnt_d, 2'b00};
        fid_sh_s  = frameid_q >> {cnt_d, 2'b00};
        txen_d    = 1'b1;
        case (state_d)
            S_PRE:       txd_d = (cnt_d == CNT_W'(PREAMBLE_NIB)) ? SFD_NIB : PRE_NIB;
            S_DA, S_SA:  txd_d = mac_sh_s[3:0];
            S_TYP: begin
                case (cnt_d[1:0])
                    2'd0:    txd_d = TYPELEN[11:8];
                    2'd1:    txd_d = TYPELEN[15:12];
                    2'd2:    txd_d = TYPELEN[3:0];
                    default: txd_d = TYPELEN[7:4];
                endcase
            end
            S_FID:       txd_d = fid_sh_s[3:0];
            S_DATA:      txd_d = wbuf_q[rptr_q][cnt_d[NIB_W-1:0]];
            S_CRC:       txd_d = crc_sh_s[3:0];
            default: begin
                txd_d  = 4'h0;
                txen_d = 1'b0;
            end
        endcase
    end

    // Read-side FSM state and registered MII outputs.
    always_ff @(posedge phy_txclk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rptr_q    <= 1'b0;
            frameid_q <= '0;
            crc_q     <= CRC_INIT;
            txd_q     <= 4'h0;
            txen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rptr_q    <= rptr_d;
            frameid_q <= frameid_d;
            crc_q     <= crc_d;
            txd_q     <= txd_d;
            txen_q    <= txen_d;
        end
    end

    assign phy_txd  = txd_q;
    assign phy_txen = txen_q;
    assign phy_txer = 1'b0;
    assign frameid  = frameid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: random payloads, byte-level frame/FCS reference model.
module tb_eth_tx_framer;

    localparam int NPAY = 16;
    localparam int DNIB = 296;

    logic       clk = 1'b0;
    logic       rst_n, tx_go, ff_bit, ff_bit_valid;
    logic [3:0] phy_txd;
    logic       phy_txen, phy_txer, overflow;
    logic [7:0] frameid;

    int checks = 0;
    int errors = 0;

    logic [3:0] pay [NPAY][DNIB];
    logic [3:0] frm [NPAY][400];
    int         frm_len [NPAY];
    int         frm_fid [NPAY];
    int         gap_before [NPAY];
    int         nfrm = 0, cur_len = 0, gap_cnt = 0, ovf_cnt = 0, bad_idle = 0;
    logic       prev_en = 1'b0;

    eth_tx_framer dut (
        .phy_txclk    (clk),
        .rst_n        (rst_n),
        .tx_go        (tx_go),
        .ff_bit       (ff_bit),
        .ff_bit_valid (ff_bit_valid),
        .phy_txd      (phy_txd),
        .phy_txen     (phy_txen),
        .phy_txer     (phy_txer),
        .frameid      (frameid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Frame capture on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (phy_txen) begin
            if (!prev_en) begin
                cur_len = 0;
                if (nfrm < NPAY) begin
                    gap_before[nfrm] = gap_cnt;
                    frm_fid[nfrm]    = int'(frameid);
                end
            end
            if (nfrm < NPAY && cur_len < 400) frm[nfrm][cur_len] = phy_txd;
            cur_len++;
            gap_cnt = 0;
        end else begin
            if (prev_en && nfrm < NPAY) begin
                frm_len[nfrm] = cur_len;
                nfrm++;
            end
            gap_cnt++;
            if (phy_txd !== 4'h0) bad_idle++;
        end
        if (phy_txer !== 1'b0) bad_idle++;
        if (overflow === 1'b1) ovf_cnt++;
        prev_en = phy_txen;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: bytes DA..payload, bytewise reflected CRC-32, nibbles low-first.
    task automatic check_frame(input int slot, input int p, input int fid, input string tag);
        logic [7:0]  b [$];
        logic [3:0]  ex [$];
        logic [47:0] da_v, sa_v, tmp;
        logic [15:0] typ_v;
        logic [31:0] crc;
        logic [3:0]  bo, be;
        int          bad, n;
        da_v  = 48'hFFFF_FFFF_FFFF;
        sa_v  = 48'h0200_0000_0001;
        typ_v = 16'h076C;
        for (int k = 0; k < 6; k++) begin
            tmp = da_v >> (8 * k);
            b.push_back(tmp[7:0]);
        end
        for (int k = 0; k < 6; k++) begin
            tmp = sa_v >> (8 * k);
            b.push_back(tmp[7:0]);
        end
        b.push_back(typ_v[15:8]);
        b.push_back(typ_v[7:0]);
        b.push_back(8'(fid));
        for (int j = 0; j < DNIB / 2; j++) b.push_back({pay[p][2*j+1], pay[p][2*j]});
        crc = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            crc = crc ^ {24'h0, b[i]};
            for (int s = 0; s < 8; s++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        for (int k = 0; k < 15; k++) ex.push_back(4'h5);
        ex.push_back(4'hD);
        foreach (b[i]) begin
            ex.push_back(b[i][3:0]);
            ex.push_back(b[i][7:4]);
        end
        for (int k = 0; k < 8; k++) ex.push_back(crc[4*k +: 4]);
        check({tag, " len"}, 64'(frm_len[slot]), 64'(ex.size()));
        check({tag, " fid"}, 64'(frm_fid[slot]), 64'(fid));
        n   = (frm_len[slot] < ex.size()) ? frm_len[slot] : ex.size();
        bad = -1;
        bo  = 4'h0;
        be  = 4'h0;
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && frm[slot][i] !== ex[i]) begin
                bad = i;
                bo  = frm[slot][i];
                be  = ex[i];
            end
        end
        checks++;
        assert (bad < 0) else begin
            errors++;
            $error("FAIL %s content: nibble %0d observed %h expected %h", tag, bad, bo, be);
        end
    endtask

    task automatic feed(input int p, input int nbits);
        for (int j = 0; j < nbits; j++) begin
            while ($urandom_range(3) == 0) @(negedge clk);
            ff_bit       = pay[p][j/4][j%4];
            ff_bit_valid = 1'b1;
            @(negedge clk);
            ff_bit_valid = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target, input string tag);
        int t = 0;
        while (nfrm < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " frame timeout"}, 64'(nfrm >= target), 64'd1);
    endtask

    task automatic wait_txen(input string tag);
        int t = 0;
        while (phy_txen !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, " start timeout"}, 64'(phy_txen), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base, hi;
        rst_n = 1'b0; tx_go = 1'b0; ff_bit = 1'b0; ff_bit_valid = 1'b0;
        for (int p = 0; p < NPAY; p++)
            for (int i = 0; i < DNIB; i++) pay[p][i] = 4'($urandom_range(15));
        for (int i = 0; i < DNIB; i++) begin
            pay[0][i] = 4'(i + 1);
            pay[1][i] = 4'h0;
        end

        repeat (3) @(negedge clk);
        check("rst txd", 64'(phy_txd), 64'h0);
        check("rst txen", 64'(phy_txen), 64'h0);
        check("rst txer", 64'(phy_txer), 64'h0);
        check("rst frameid", 64'(frameid), 64'h0);
        check("rst overflow", 64'(overflow), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Counting pattern, including start latency after the last bit.
        tx_go = 1'b1;
        feed(0, DNIB * 4);
        check("latency edge N", 64'(phy_txen), 64'd0);
        @(negedge clk);
        check("latency edge N+1", 64'(phy_txen), 64'd1);
        wait_frames(1, "pattern");
        check_frame(0, 0, 0, "pattern");

        // All-zero payload: FCS against the software reference.
        feed(1, DNIB * 4);
        wait_frames(2, "zeros");
        check_frame(1, 1, 1, "zeros");

        // Three consecutive buffers after reset: frame IDs 0,1,2.
        pulse_reset();
        base = nfrm;
        for (int k = 0; k < 3; k++) feed(2 + k, DNIB * 4);
        wait_frames(base + 3, "three");
        for (int k = 0; k < 3; k++) begin
            check_frame(base + k, 2 + k, k, $sformatf("three%0d", k));
            check($sformatf("three%0d gap>=24", k), 64'(gap_before[base + k] >= 24), 64'd1);
        end

        // Both buffers full with tx_go low, one extra bit overflows and is dropped.
        tx_go = 1'b0;
        base  = nfrm;
        feed(5, DNIB * 4);
        feed(6, DNIB * 4);
        check("held no frame", 64'(nfrm), 64'(base));
        ff_bit = 1'b1; ff_bit_valid = 1'b1;
        @(negedge clk);
        ff_bit_valid = 1'b0;
        check("overflow pulse", 64'(overflow), 64'd1);
        @(negedge clk);
        check("overflow one cycle", 64'(overflow), 64'd0);
        tx_go = 1'b1;
        wait_frames(base + 2, "ovf");
        check_frame(base, 5, 3, "ovf a");
        check_frame(base + 1, 6, 4, "ovf b");
        check("back-to-back gap", 64'(gap_before[base + 1]), 64'd25);
        feed(7, DNIB * 4);
        wait_frames(base + 3, "post-ovf");
        check_frame(base + 2, 7, 5, "post-ovf");

        // Buffer completes on the same edge the previous frame enters CRC.
        tx_go = 1'b0;
        base  = nfrm;
        feed(8, DNIB * 4);
        feed(9, DNIB * 4 - 1);
        tx_go = 1'b1;
        wait_txen("simul");
        repeat (341) @(negedge clk);
        ff_bit = pay[9][DNIB-1][3]; ff_bit_valid = 1'b1;
        @(negedge clk);
        ff_bit_valid = 1'b0;
        check("simul no overflow", 64'(overflow), 64'd0);
        wait_frames(base + 2, "simul");
        check_frame(base, 8, 6, "simul a");
        check_frame(base + 1, 9, 7, "simul b");
        check("simul gap", 64'(gap_before[base + 1]), 64'd25);

        // Reset at DATA nibble 100 abandons the frame and empties both buffers.
        tx_go = 1'b0;
        feed(10, DNIB * 4);
        feed(11, DNIB * 4);
        tx_go = 1'b1;
        wait_txen("midrst");
        repeat (146) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst txen", 64'(phy_txen), 64'd0);
        check("midrst frameid", 64'(frameid), 64'd0);
        rst_n = 1'b1;
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (phy_txen === 1'b1) hi++;
        end
        check("midrst buffers empty", 64'(hi), 64'd0);
        base = nfrm;
        feed(12, DNIB * 4);
        wait_frames(base + 1, "after rst");
        check_frame(base, 12, 0, "after rst");

        check("idle txd/txer", 64'(bad_idle), 64'd0);
        check("total overflows", 64'(ovf_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
